// File: rtl/wind_pkg.sv
// wind_pkg: shared types, pattern constants and step classifier for the wind decoder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package wind_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_CALM = 2'b01,
        DIR_RL   = 2'b10,
        DIR_LR   = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HUNT  = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    // LED patterns, bit 2 = left, bit 1 = middle, bit 0 = right
    localparam logic [2:0] PAT_L  = 3'b100;
    localparam logic [2:0] PAT_M  = 3'b010;
    localparam logic [2:0] PAT_R  = 3'b001;
    localparam logic [2:0] PAT_LR = 3'b101;

    // Active-low gfedcba glyphs
    localparam logic [6:0] SEG_CALM = 7'b1000110;
    localparam logic [6:0] SEG_RL   = 7'b1000111;
    localparam logic [6:0] SEG_LR   = 7'b0101111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef struct packed {
        dir_t cls;      // class of the step when neither flag is set
        logic hold;     // cur == prev
        logic illegal;  // both legal but not an allowed transition
    } step_t;

    function automatic logic pat_legal(input logic [2:0] p);
        return (p == PAT_L) || (p == PAT_M) || (p == PAT_R) || (p == PAT_LR);
    endfunction

    // Assumes both patterns are legal; the caller screens cur first and
    // prev only ever holds legal patterns once the decoder is seeded.
    function automatic step_t classify(input logic [2:0] prev, input logic [2:0] cur);
        step_t s;
        s.cls     = DIR_NONE;
        s.hold    = 1'b0;
        s.illegal = 1'b0;
        if (cur == prev) begin
            s.hold = 1'b1;
        end else begin
            case ({prev, cur})
                {PAT_LR, PAT_M}, {PAT_M, PAT_LR}:               s.cls = DIR_CALM;
                {PAT_R, PAT_M}, {PAT_M, PAT_L}, {PAT_L, PAT_R}: s.cls = DIR_RL;
                {PAT_L, PAT_M}, {PAT_M, PAT_R}, {PAT_R, PAT_L}: s.cls = DIR_LR;
                default:                                        s.illegal = 1'b1;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/wind_dir_seg7.sv
// wind_dir_seg7: registered active-low seven-segment glyph for a decoded wind direction.
// Latency: 1 clk from dir_i/valid_i to seg_o.
// Backpressure: none. Ports: clk, reset (sync, active-low), dir_i, valid_i in; seg_o out.
module wind_dir_seg7
    import wind_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] dir_i,
    input  logic       valid_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_q, seg_d;

    always_comb begin
        seg_d = SEG_DASH;
        if (valid_i) begin
            case (dir_t'(dir_i))
                DIR_CALM: seg_d = SEG_CALM;
                DIR_RL:   seg_d = SEG_RL;
                DIR_LR:   seg_d = SEG_LR;
                default:  seg_d = SEG_DASH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_q <= SEG_DASH;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/wind_decoder.sv
// wind_decoder: recovers calm / right-to-left / left-to-right from a tick-sampled 3-bit LED stream.
// Latency: dir/valid/err registered on the tick edge (visible next cycle); hex one cycle later.
// Backpressure: none; every tick is consumed. Ports: clk, reset (sync, active-low), tick, pattern in;
//   dir, valid, err, hex out. Define WIND_DECODER_HEX_EN to build the glyph stage, else hex = 7'h7F.
module wind_decoder
    import wind_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] pattern,
    output logic [1:0] dir,
    output logic       valid,
    output logic       err,
    output logic [6:0] hex
);

    localparam logic [3:0] LOCK_W = 4'(LOCK_COUNT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    dir_t       cand_q, cand_d;
    logic [2:0] prev_q, prev_d;
    dir_t       dir_q, dir_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    step_t      step;
    logic       cur_legal;
    logic [3:0] cnt_inc;
    logic [3:0] cnt_next;

    assign step      = classify(prev_q, pattern);
    assign cur_legal = pat_legal(pattern);
    assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        prev_d   = prev_q;
        dir_d    = dir_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        cnt_next = cnt_q;

        if (tick) begin
            if (!cur_legal) begin
                // prev is kept: it is only updated by legal samples
                err_d   = 1'b1;
                state_d = S_EMPTY;
                cnt_d   = 4'd0;
                cand_d  = DIR_NONE;
                valid_d = 1'b0;
                dir_d   = DIR_NONE;
            end else begin
                case (state_q)
                    S_EMPTY: begin
                        prev_d  = pattern;
                        state_d = S_HUNT;
                        cnt_d   = 4'd0;
                        cand_d  = DIR_NONE;
                    end
                    S_HUNT, S_LOCK: begin
                        if (step.hold) begin
                            // repeated sample: not a step, nothing moves
                        end else if (step.illegal) begin
                            err_d   = 1'b1;
                            state_d = S_HUNT;
                            cnt_d   = 4'd0;
                            cand_d  = DIR_NONE;
                            prev_d  = pattern;
                            valid_d = 1'b0;
                            dir_d   = DIR_NONE;
                        end else if (state_q == S_LOCK) begin
                            prev_d = pattern;
                            if (step.cls != dir_q) begin
                                state_d = S_HUNT;
                                cand_d  = step.cls;
                                cnt_d   = 4'd1;
                                valid_d = 1'b0;
                                dir_d   = DIR_NONE;
                            end
                        end else begin
                            prev_d = pattern;
                            // cand starts as NONE, so the first step always restarts the run at 1
                            if (step.cls == cand_q) begin
                                cnt_next = cnt_inc;
                            end else begin
                                cand_d   = step.cls;
                                cnt_next = 4'd1;
                            end
                            cnt_d = cnt_next;
                            if (cnt_next == LOCK_W) begin
                                state_d = S_LOCK;
                                dir_d   = step.cls;
                                valid_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d = S_EMPTY;
                        valid_d = 1'b0;
                        dir_d   = DIR_NONE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            cnt_q   <= 4'd0;
            cand_q  <= DIR_NONE;
            prev_q  <= 3'b000;
            dir_q   <= DIR_NONE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            prev_q  <= prev_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign dir   = dir_q;
    assign valid = valid_q;
    assign err   = err_q;

`ifdef WIND_DECODER_HEX_EN
    wind_dir_seg7 u_seg7 (
        .clk     (clk),
        .reset   (reset),
        .dir_i   (dir_q),
        .valid_i (valid_q),
        .seg_o   (hex)
    );
`else
    assign hex = SEG_OFF;
`endif

endmodule

// File: tb/tb_wind_decoder.sv
// tb_wind_decoder: directed vector table plus randomized run against a behavioural model.
// Latency: n/a. Backpressure: n/a.
// Ports: none (top-level bench).
module tb_wind_decoder;

    localparam int LC = 3;
`ifdef WIND_DECODER_HEX_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] pattern = 3'b000;
    logic [1:0] dir;
    logic       valid;
    logic       err;
    logic [6:0] hex;

    wind_decoder #(.LOCK_COUNT(LC)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .pattern (pattern),
        .dir     (dir),
        .valid   (valid),
        .err     (err),
        .hex     (hex)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    // The decoder is described as: a seed sample, then runs of same-class steps;
    // a run of LC steps locks, a differing step while locked breaks the lock.
    bit         m_have_prev;
    logic [2:0] m_prev;
    bit         m_locked;
    int         m_lock_dir;
    int         m_run_cls;
    int         m_run_len;
    bit         m_err;
    logic [6:0] m_hex;

    function automatic bit is_legal(input logic [2:0] p);
        return (p == 3'b001) || (p == 3'b010) || (p == 3'b100) || (p == 3'b101);
    endfunction

    // position of a single lit LED counted from the right; -1 otherwise
    function automatic int rot_idx(input logic [2:0] p);
        if (p == 3'b001) return 0;
        if (p == 3'b010) return 1;
        if (p == 3'b100) return 2;
        return -1;
    endfunction

    // 1 calm, 2 right-to-left (light moves leftwards), 3 left-to-right, 0 illegal
    function automatic int step_class(input logic [2:0] a, input logic [2:0] b);
        int i, j;
        if ((a == 3'b101 && b == 3'b010) || (a == 3'b010 && b == 3'b101)) return 1;
        i = rot_idx(a);
        j = rot_idx(b);
        if (i < 0 || j < 0) return 0;
        if (j == (i + 1) % 3) return 2;
        if (i == (j + 1) % 3) return 3;
        return 0;
    endfunction

    function automatic logic [6:0] glyph(input bit locked, input int d);
        if (!HEX_EN) return 7'h7F;
        if (!locked) return 7'b0111111;
        case (d)
            1:       return 7'b1000110;
            2:       return 7'b1000111;
            3:       return 7'b0101111;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit t, input logic [2:0] p);
        logic [6:0] hn;
        int c;
        hn = glyph(m_locked, m_lock_dir);
        if (!r) begin
            m_have_prev = 1'b0; m_prev = 3'b000; m_locked = 1'b0; m_lock_dir = 0;
            m_run_cls = 0; m_run_len = 0; m_err = 1'b0; m_hex = glyph(1'b0, 0);
            return;
        end
        m_hex = hn;
        m_err = 1'b0;
        if (!t) return;
        if (!is_legal(p)) begin
            m_err = 1'b1; m_have_prev = 1'b0; m_locked = 1'b0; m_run_cls = 0; m_run_len = 0;
            return;
        end
        if (!m_have_prev) begin
            m_have_prev = 1'b1; m_prev = p; m_run_cls = 0; m_run_len = 0;
            return;
        end
        if (p == m_prev) return;
        c = step_class(m_prev, p);
        m_prev = p;
        if (c == 0) begin
            m_err = 1'b1; m_locked = 1'b0; m_run_cls = 0; m_run_len = 0;
            return;
        end
        if (m_locked) begin
            if (c != m_lock_dir) begin
                m_locked = 1'b0; m_run_cls = c; m_run_len = 1;
            end
        end else begin
            if (c == m_run_cls) m_run_len++;
            else begin m_run_cls = c; m_run_len = 1; end
            if (m_run_len >= LC) begin m_locked = 1'b1; m_lock_dir = c; end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic cycle(input bit r, input bit t, input logic [2:0] p);
        @(negedge clk);
        reset = r; tick = t; pattern = p;
        @(posedge clk);
        model_step(r, t, p);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         r;
        bit         t;
        logic [2:0] p;
        logic [1:0] d;
        bit         v;
        bit         e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit r, input bit t, input logic [2:0] p,
                                input logic [1:0] d, input bit v, input bit e);
        vec_t x;
        x.r = r; x.t = t; x.p = p; x.d = d; x.v = v; x.e = e;
        return x;
    endfunction

    function automatic logic [2:0] next_pat(input int mode, input logic [2:0] last);
        if (mode == 1) return (last == 3'b010) ? 3'b101 : 3'b010;
        if (last == 3'b101) return 3'b010;
        if (mode == 2) return (last == 3'b100) ? 3'b001 : {last[1:0], 1'b0};
        return (last == 3'b001) ? 3'b100 : {1'b0, last[2:1]};
    endfunction

    // ---------------- test ----------------
    int         mode;
    logic [2:0] last;
    bit         rr, tt;
    int         sel;
    logic [2:0] pp;

    initial begin
        // reset, reset-vs-tick
        tbl.push_back(mk(0, 0, 3'b000, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 3'b101, 2'b00, 0, 0));
        tbl.push_back(mk(1, 0, 3'b000, 2'b00, 0, 0));
        // calm lock after seed + 3 steps
        tbl.push_back(mk(1, 1, 3'b101, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b010, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b101, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b010, 2'b01, 1, 0));
        tbl.push_back(mk(1, 0, 3'b000, 2'b01, 1, 0));
        tbl.push_back(mk(1, 0, 3'b111, 2'b01, 1, 0));
        tbl.push_back(mk(1, 1, 3'b101, 2'b01, 1, 0));
        // 101 -> 001 illegal transition while locked
        tbl.push_back(mk(1, 1, 3'b001, 2'b00, 0, 1));
        tbl.push_back(mk(1, 0, 3'b000, 2'b00, 0, 0));
        // right-to-left lock, broken by a left-to-right step, relock left-to-right
        tbl.push_back(mk(1, 1, 3'b010, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b100, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b001, 2'b10, 1, 0));
        tbl.push_back(mk(1, 1, 3'b100, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b010, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b001, 2'b11, 1, 0));
        tbl.push_back(mk(1, 1, 3'b010, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b100, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b001, 2'b10, 1, 0));
        // illegal pattern while locked, then again from empty
        tbl.push_back(mk(1, 1, 3'b011, 2'b00, 0, 1));
        tbl.push_back(mk(1, 1, 3'b011, 2'b00, 0, 1));
        tbl.push_back(mk(1, 0, 3'b000, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b100, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b100, 2'b00, 0, 0));
        // holds ignored; reset coincides with the would-be locking tick
        tbl.push_back(mk(0, 0, 3'b000, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b001, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b001, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b001, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b010, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b100, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 3'b001, 2'b00, 0, 0));
        // holds inside a run still lock; reset mid-lock; illegal 000 from empty
        tbl.push_back(mk(1, 1, 3'b001, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b010, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b010, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b100, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b001, 2'b10, 1, 0));
        tbl.push_back(mk(0, 0, 3'b000, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 3'b000, 2'b00, 0, 1));
        tbl.push_back(mk(1, 0, 3'b000, 2'b00, 0, 0));

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].t, tbl[i].p);
            check($sformatf("vec%0d dir", i), {6'd0, dir}, {6'd0, tbl[i].d});
            check($sformatf("vec%0d valid", i), {7'd0, valid}, {7'd0, tbl[i].v});
            check($sformatf("vec%0d err", i), {7'd0, err}, {7'd0, tbl[i].e});
            check($sformatf("vec%0d hex", i), {1'b0, hex}, {1'b0, m_hex});
        end

        // randomized run against the model
        mode = 2;
        last = 3'b001;
        for (int k = 0; k < 3000; k++) begin
            rr  = ($urandom_range(0, 199) != 0);
            tt  = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 99);
            if ($urandom_range(0, 19) == 0) mode = $urandom_range(1, 3);
            if (sel < 4) begin
                case ($urandom_range(0, 3))
                    0:       pp = 3'b000;
                    1:       pp = 3'b011;
                    2:       pp = 3'b110;
                    default: pp = 3'b111;
                endcase
            end else if (sel < 12) begin
                case ($urandom_range(0, 3))
                    0:       pp = 3'b001;
                    1:       pp = 3'b010;
                    2:       pp = 3'b100;
                    default: pp = 3'b101;
                endcase
            end else if (sel < 18) begin
                pp = last;
            end else begin
                pp = next_pat(mode, last);
            end
            if (tt && is_legal(pp)) last = pp;
            cycle(rr, tt, pp);
            check("rnd dir", {6'd0, dir}, m_locked ? 8'(m_lock_dir) : 8'd0);
            check("rnd valid", {7'd0, valid}, {7'd0, m_locked});
            check("rnd err", {7'd0, err}, {7'd0, m_err});
            check("rnd hex", {1'b0, hex}, {1'b0, m_hex});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
